gaussian_window_gen: RTL and testbench



---
 rtl/gaussian_pkg.sv | 16 +
 rtl/gaussian_linebuf.sv | 27 ++
 rtl/gaussian_window_gen.sv | 104 ++++++++++
 tb/tb_gaussian_window_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/gaussian_pkg.sv
// Shared constants for the Gaussian filter path (window producer and core).
package gaussian_pkg;

   localparam int unsigned BITS    = 8;
   localparam int unsigned WIDTH   = 7;
   localparam int unsigned MASKLEN = WIDTH * WIDTH * BITS;
   localparam int unsigned LB_W    = (WIDTH - 1) * BITS;

   typedef logic [BITS-1:0] pixel_t;

   // Bit offset of window element (i,j); i=0 is the oldest row, j=0 the leftmost column.
   function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j);
      return (i * WIDTH + j) * BITS;
   endfunction

endpackage

// File: rtl/gaussian_linebuf.sv
// Line buffer: one word per image column holding the WIDTH-1 most recent lines,
// oldest line in the LSBs. Asynchronous read-before-write at the current column.
module gaussian_linebuf
   import gaussian_pkg::*;
#(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   addr,
   input  logic [BITS-1:0] pix_in,
   output logic [LB_W-1:0] col_out
);

   logic [LB_W-1:0] mem [DEPTH];

   assign col_out = mem[addr];

   // Shift the column down one line: drop the oldest pixel, append the new one as newest.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= {pix_in, col_out[LB_W-1:BITS]};
      end
   end

endmodule

// File: rtl/gaussian_window_gen.sv
// Raster-to-window producer: turns a pixel stream into packed WIDTHxWIDTH windows
// for every fully interior pixel position, behind a single-entry output register.
module gaussian_window_gen
   import gaussian_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_valid,
   output logic               pix_ready,
   input  logic [BITS-1:0]    pix_in,
   output logic               win_valid,
   input  logic               win_ready,
   output logic [MASKLEN-1:0] window,
   output logic               frame_done
);

   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [CW-1:0]      col;
   logic [RW-1:0]      row;
   logic               accept;
   logic               produce;
   logic               col_last;
   logic               row_last;
   logic               last_q;
   logic [LB_W-1:0]    lb_col;
   logic [MASKLEN-1:0] win_d;

   // Output register is free when empty or being drained this cycle.
   assign pix_ready = !win_valid || win_ready;
   assign accept    = pix_valid && pix_ready;
   assign col_last  = (col == CW'(IMG_W - 1));
   assign row_last  = (row == RW'(IMG_H - 1));
   assign produce   = (row >= RW'(WIDTH - 1)) && (col >= CW'(WIDTH - 1));

   gaussian_linebuf #(
      .DEPTH (IMG_W),
      .AW    (CW)
   ) u_linebuf (
      .clk     (clk),
      .we      (accept),
      .addr    (col),
      .pix_in  (pix_in),
      .col_out (lb_col)
   );

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Next window: every row shifts one column left; new right column is the buffered column plus pix_in.
   always_comb begin
      win_d = window;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         for (int unsigned j = 0; j < WIDTH - 1; j++) begin
            win_d[elem_lsb(i, j) +: BITS] = window[elem_lsb(i, j + 1) +: BITS];
         end
      end
      for (int unsigned i = 0; i < WIDTH - 1; i++) begin
         win_d[elem_lsb(i, WIDTH - 1) +: BITS] = lb_col[i*BITS +: BITS];
      end
      win_d[elem_lsb(WIDTH - 1, WIDTH - 1) +: BITS] = pix_in;
   end

   // Window shift register doubles as the output data register; it only moves on accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         window <= win_d;
      end
   end

   // Output handshake state and end-of-frame pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid  <= 1'b0;
         last_q     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= win_valid && win_ready && last_q;
         if (accept) begin
            win_valid <= produce;
            last_q    <= row_last && col_last;
         end else if (win_ready) begin
            win_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gaussian_window_gen.sv
// Randomized self-checking bench for gaussian_window_gen on an 8x8 image, WIDTH=7.
module tb_gaussian_window_gen;

   localparam int unsigned IW = 8;
   localparam int unsigned IH = 8;
   localparam int unsigned WD = 7;
   localparam int unsigned BT = 8;
   localparam int unsigned ML = WD * WD * BT;
   localparam int BUDGET = 3000;

   localparam int M_STREAM = 0;
   localparam int M_BP     = 1;
   localparam int M_RAND   = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          pix_valid;
   logic          pix_ready;
   logic [BT-1:0] pix_in;
   logic          win_valid;
   logic          win_ready;
   logic [ML-1:0] window;
   logic          frame_done;

   always #5 clk = ~clk;

   gaussian_window_gen #(
      .IMG_W (IW),
      .IMG_H (IH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_in     (pix_in),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .window     (window),
      .frame_done (frame_done)
   );

   int total = 0;
   int bad   = 0;

   logic [ML-1:0] exp_q [$];
   bit            last_q [$];
   bit            pend;
   bit            fd_exp;
   int            nwin;
   int            nfd;

   task automatic check(input string tag, input logic [ML-1:0] got, input logic [ML-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Window for pixel (r,c) of a frame whose pixel value is base + row*IW + col.
   function automatic logic [ML-1:0] model_win(input int base, input int r, input int c);
      logic [ML-1:0] w;
      w = '0;
      for (int i = 0; i < int'(WD); i++)
         for (int j = 0; j < int'(WD); j++)
            w[(i*WD+j)*BT +: BT] = BT'(base + (r - int'(WD) + 1 + i) * int'(IW) + (c - int'(WD) + 1 + j));
      return w;
   endfunction

   task automatic queue_frame(input int base);
      for (int r = WD - 1; r < int'(IH); r++)
         for (int c = WD - 1; c < int'(IW); c++) begin
            exp_q.push_back(model_win(base, r, c));
            last_q.push_back((r == int'(IH) - 1) && (c == int'(IW) - 1));
         end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; pix_valid = 1'b0; win_ready = 1'b0; pix_in = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_pix_ready", pix_ready, 1);
      check("rst_win_valid", win_valid, 0);
      check("rst_frame_done", frame_done, 0);
      pend = 0; fd_exp = 0; nwin = 0; nfd = 0;
      exp_q.delete(); last_q.delete();
   endtask

   // Feed npix raster pixels (value = index) and drain; checks every cycle against the model.
   task automatic run(input int npix, input int mode, input bit first_chk);
      int  idx = 0;
      int  cyc = 0;
      int  hold = 0;
      bit  hs, acc, prod, mready;
      int  r, c;
      logic [ML-1:0] w;
      while ((idx < npix || pend) && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         check("frame_done", frame_done, fd_exp);
         if (frame_done) nfd++;
         check("win_valid", win_valid, pend);
         pix_valid = (idx < npix) && (mode == M_RAND ? ($urandom_range(0, 1) == 1) : 1'b1);
         pix_in    = BT'(idx);
         if (mode == M_RAND)
            win_ready = ($urandom_range(0, 1) == 1);
         else if (mode == M_BP && pend && hold < 5) begin
            win_ready = 1'b0;
            hold++;
         end else
            win_ready = 1'b1;
         #1;
         mready = !pend || win_ready;
         check("pix_ready", pix_ready, mready);
         if (pend) begin
            if (exp_q.size() == 0) check("win_unexpected", 1, 0);
            else begin
               check("window", window, exp_q[0]);
               if (first_chk && nwin == 0) begin
                  w = window;
                  check("el00", w[0 +: BT], 0);
                  check("el66", w[(6*WD+6)*BT +: BT], 54);
                  check("el33", w[(3*WD+3)*BT +: BT], 27);
               end
            end
         end
         hs  = pend && win_ready;
         acc = pix_valid && mready;
         fd_exp = 1'b0;
         if (hs) begin
            nwin++;
            if (exp_q.size() != 0) begin
               fd_exp = last_q[0];
               void'(exp_q.pop_front());
               void'(last_q.pop_front());
            end
         end
         if (acc) begin
            r = (idx / int'(IW)) % int'(IH);
            c = idx % int'(IW);
            prod = (r >= int'(WD) - 1) && (c >= int'(WD) - 1);
            pend = prod;
            idx++;
         end else if (hs) begin
            pend = 1'b0;
         end
      end
      check("timeout", cyc < BUDGET, 1);
      @(negedge clk);
      check("frame_done_end", frame_done, fd_exp);
      if (frame_done) nfd++;
      check("win_valid_end", win_valid, pend);
      fd_exp = 1'b0;
      pix_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pix_valid = 1'b0; win_ready = 1'b0; pix_in = '0;

      // Streaming frame
      do_reset();
      queue_frame(0);
      run(64, M_STREAM, 1'b1);
      check("stream_nwin", nwin, 4);
      check("stream_nfd", nfd, 1);
      check("stream_left", exp_q.size(), 0);

      // Backpressure after first window
      do_reset();
      queue_frame(0);
      run(64, M_BP, 1'b1);
      check("bp_nwin", nwin, 4);
      check("bp_nfd", nfd, 1);
      check("bp_left", exp_q.size(), 0);

      // Random valid / ready, a few frames
      for (int k = 0; k < 3; k++) begin
         do_reset();
         queue_frame(0);
         run(64, M_RAND, 1'b0);
         check("rand_nwin", nwin, 4);
         check("rand_nfd", nfd, 1);
         check("rand_left", exp_q.size(), 0);
      end

      // Reset after pixel (6,3), then a full frame
      do_reset();
      run(52, M_STREAM, 1'b0);
      check("abort_nwin", nwin, 0);
      do_reset();
      queue_frame(0);
      run(64, M_RAND, 1'b1);
      check("after_abort_nwin", nwin, 4);
      check("after_abort_nfd", nfd, 1);

      // Two back-to-back frames, second offset by 64
      do_reset();
      queue_frame(0);
      queue_frame(64);
      run(128, M_STREAM, 1'b0);
      check("two_nwin", nwin, 8);
      check("two_nfd", nfd, 2);
      check("two_left", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
